accumulator_bank: RTL
=====================

ACCUMULATOR_BANK -- requirements
Module: accumulator_bank

Interface
REQ-001 Parameter ACC_WIDTH, default 24: accumulator width per channel in bits; legal range 2..32.
REQ-002 Parameter ADD_WIDTH, default 8: operand width in bits; ADD_WIDTH SHALL be no greater than ACC_WIDTH.
REQ-003 Parameter NUM_CH, default 4: channel count, a power of two in 2..16; CH_BITS = log2(NUM_CH).
REQ-004 clk  in  1  sole clock; all state SHALL update on the rising edge only.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  operation request; accepted when in_valid && in_ready.
REQ-007 in_ch  in  CH_BITS  target channel of the operation.
REQ-008 in_op  in  2  operation: 00 add, 01 subtract, 10 clear channel, 11 load (accumulator = zero-extended in_value).
REQ-009 in_value  in  ADD_WIDTH  unsigned operand.
REQ-010 sat_en  in  1  1 = saturate at 0 / all-ones; 0 = modulo 2^ACC_WIDTH wrap; sampled with each accepted op.
REQ-011 clr_all  in  1  one-cycle request to start a sweep that clears every channel.
REQ-012 in_ready  out  1  1 when operations can be accepted (state IDLE).
REQ-013 rd_ch  in  CH_BITS  read-port channel select.
REQ-014 rd_data  out  ACC_WIDTH  registered value of channel rd_ch.
REQ-015 ovf  out  NUM_CH  per-channel sticky overflow/underflow flag.
REQ-016 msb  out  NUM_CH  bit ACC_WIDTH-1 of each channel accumulator, driven directly from the state registers.

Function
REQ-017 Each accepted op SHALL update only channel in_ch, on the accepting edge; the new value SHALL be visible on msb one cycle after acceptance and on rd_data one cycle after that (read latency 1).
REQ-018 Add/subtract SHALL be computed at ACC_WIDTH+1 bits with in_value zero-extended to that width; the extra bit is the carry-out for add or the borrow for subtract.
REQ-019 On carry/borrow with sat_en=0: result SHALL wrap modulo 2^ACC_WIDTH and the channel's ovf bit SHALL be set.
REQ-020 On carry/borrow with sat_en=1: result SHALL clamp to 2^ACC_WIDTH-1 (add) or 0 (subtract) and the channel's ovf bit SHALL be set.
REQ-021 Clear (op 10) and load (op 11) SHALL write 0 or zero-extended in_value respectively, SHALL clear that channel's ovf bit, and SHALL ignore sat_en.
REQ-022 ovf bits SHALL only be cleared by rst, clear, load or the clear-all sweep.
REQ-023 FSM states: IDLE and SWEEP. In IDLE, clr_all=1 SHALL go to SWEEP with sweep index 0; any in_valid in that same cycle SHALL still be accepted and executed.
REQ-024 In SWEEP: channel[index] and ovf[index] SHALL be cleared each cycle, index incremented; after index NUM_CH-1 is cleared the FSM SHALL return to IDLE, so SWEEP lasts exactly NUM_CH cycles.
REQ-025 in_ready SHALL be 0 throughout SWEEP; in_valid SHALL be ignored there, and clr_all SHALL be ignored in SWEEP.
REQ-026 rd_data SHALL sample the pre-update value of the channel when a write to rd_ch occurs on the same edge, i.e. no bypass.
REQ-027 Read port SHALL operate in every state, independent of in_valid.

Reset
REQ-028 While rst=1 at an edge: all accumulators 0, ovf all 0, rd_data 0, FSM IDLE, sweep index 0; in_ready SHALL read 1 from the first edge after rst falls.
REQ-029 rst asserted mid-SWEEP SHALL abort the sweep and reset all state per REQ-028; rst SHALL override in_valid and clr_all.

Verification
REQ-030 Reset, ch1 add 0xFF x3 (sat_en=0) -> ch1=0x0002FD, rd_data(rd_ch=1)=0x0002FD, ovf=0, other channels 0.
REQ-031 ch0 load 0xFF, then add 0x01 repeatedly until wrap with ACC_WIDTH=8 build, sat_en=0 -> value 0x00 after wrap, ovf[0]=1, msb[0]=0; with sat_en=1 -> holds 0xFF, ovf[0]=1.
REQ-032 ch2=0x000005, subtract 0x09 sat_en=1 -> 0x000000, ovf[2]=1; then sat_en=0 subtract 0x01 -> 0xFFFFFF.
REQ-033 All channels nonzero, clr_all=1 with in_valid add to ch3 same cycle -> in_ready=0 for exactly 4 cycles, in_valid during SWEEP has no effect, all channels and ovf 0 at return to IDLE.
REQ-034 Write ch1 and read rd_ch=1 on same edge -> rd_data shows the old value, and the new value on the following cycle.
REQ-035 rst pulse at sweep cycle 2 -> all state zero, in_ready=1 after reset, subsequent add to ch0 of 0x10 -> 0x000010.

Source files
------------

// File: rtl/accumulator_bank.sv
// rtl/accumulator_bank.sv - multi-channel add/sub/clear/load accumulator bank with clear-all sweep
module accumulator_bank #(
    parameter int ACC_WIDTH = 24,
    parameter int ADD_WIDTH = 8,
    parameter int NUM_CH    = 4,
    localparam int CH_BITS  = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [CH_BITS-1:0]   in_ch,
    input  logic [1:0]           in_op,
    input  logic [ADD_WIDTH-1:0] in_value,
    input  logic                 sat_en,
    input  logic                 clr_all,
    output logic                 in_ready,
    input  logic [CH_BITS-1:0]   rd_ch,
    output logic [ACC_WIDTH-1:0] rd_data,
    output logic [NUM_CH-1:0]    ovf,
    output logic [NUM_CH-1:0]    msb
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t               state, next_state;
    logic [CH_BITS-1:0]   sweep_idx, next_sweep_idx;
    logic [ACC_WIDTH-1:0] acc [NUM_CH];

    logic                 accept;
    logic [ACC_WIDTH:0]   operand_ext, sum_ext, diff_ext;
    logic [ACC_WIDTH-1:0] op_result;
    logic                 op_ovf;

    assign in_ready    = (state == IDLE);
    assign accept      = in_valid && in_ready;
    // One extra bit holds carry-out on add and borrow on subtract
    assign operand_ext = (ACC_WIDTH+1)'(in_value);
    assign sum_ext     = {1'b0, acc[in_ch]} + operand_ext;
    assign diff_ext    = {1'b0, acc[in_ch]} - operand_ext;

    always_comb begin
        op_result = acc[in_ch];
        op_ovf    = ovf[in_ch];
        case (in_op)
            OP_ADD: begin
                op_result = (sum_ext[ACC_WIDTH] && sat_en) ? '1 : sum_ext[ACC_WIDTH-1:0];
                op_ovf    = ovf[in_ch] | sum_ext[ACC_WIDTH];
            end
            OP_SUB: begin
                op_result = (diff_ext[ACC_WIDTH] && sat_en) ? '0 : diff_ext[ACC_WIDTH-1:0];
                op_ovf    = ovf[in_ch] | diff_ext[ACC_WIDTH];
            end
            OP_CLR: begin
                op_result = '0;
                op_ovf    = 1'b0;
            end
            default: begin
                op_result = ACC_WIDTH'(in_value);
                op_ovf    = 1'b0;
            end
        endcase
    end

    always_comb begin
        next_state     = state;
        next_sweep_idx = sweep_idx;
        case (state)
            IDLE: begin
                if (clr_all) begin
                    next_state     = SWEEP;
                    next_sweep_idx = '0;
                end
            end
            SWEEP: begin
                next_sweep_idx = sweep_idx + CH_BITS'(1);
                if (sweep_idx == LAST_CH) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sweep_idx <= '0;
        end else begin
            state     <= next_state;
            sweep_idx <= next_sweep_idx;
        end
    end

    // Accepted ops and sweep clears never coincide: accept requires IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
            ovf     <= '0;
            rd_data <= '0;
        end else begin
            rd_data <= acc[rd_ch];
            if (accept) begin
                acc[in_ch] <= op_result;
                ovf[in_ch] <= op_ovf;
            end
            if (state == SWEEP) begin
                acc[sweep_idx] <= '0;
                ovf[sweep_idx] <= 1'b0;
            end
        end
    end

    always_comb begin
        msb = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            msb[i] = acc[i][ACC_WIDTH-1];
        end
    end
endmodule
